ioc_spi_initiator: RTL and testbench

- Command initiator for the FPGA's register-mapped control modules. It is the other end of the i_ioc / i_data_in / i_fetch_cmd / i_load_cmd / i_cs register interface.
- Accepts 2-byte SPI transactions from the host (SPI mode 0, MSB first) and decodes a command byte.
- Drives one-hot chip-select, IOC address, write data and single-cycle fetch/load strobes to the modules.
- For reads, returns the selected module's registered read byte on MISO during the second byte.

---
 rtl/ioc_spi_pkg.sv | 27 ++
 rtl/ioc_spi_initiator_sync.sv | 32 +++
 rtl/ioc_spi_initiator.sv | 184 ++++++++++++++++++
 tb/tb_ioc_spi_initiator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ioc_spi_pkg.sv
// Shared constants, command field positions and FSM encoding for the IOC SPI initiator.
package ioc_spi_pkg;

    localparam int unsigned CMD_RW_BIT  = 7;
    localparam int unsigned CMD_MOD_MSB = 6;
    localparam int unsigned CMD_MOD_LSB = 5;
    localparam int unsigned CMD_IOC_MSB = 4;

    localparam int unsigned IOC_W  = 5;
    localparam int unsigned MOD_W  = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 5;

    localparam logic [CNT_W-1:0] CMD_BITS   = CNT_W'(8);
    localparam logic [CNT_W-1:0] TOTAL_BITS = CNT_W'(16);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_WAIT_RD,
        ST_DATA,
        ST_LOAD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ioc_spi_initiator_sync.sv
// Multi-stage synchroniser with single-cycle rise/fall pulses from the synchronised level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic i_sys_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Pulses are decoded from two flops so the FSM reacts one cycle earlier.
    assign o_level  = r_sync[SYNC_STAGES-1];
    assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall_c = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/ioc_spi_initiator.sv
// SPI-slave front end that turns 2-byte host transactions into IOC fetch/load strobes.
module ioc_spi_initiator
    import ioc_spi_pkg::*;
#(
    parameter int unsigned NUM_MODULES = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        i_sys_clk,
    input  logic                        i_rst,
    input  logic                        i_spi_sck,
    input  logic                        i_spi_mosi,
    input  logic                        i_spi_cs_b,
    output logic                        o_spi_miso,
    output logic [IOC_W-1:0]            o_ioc,
    output logic [BYTE_W-1:0]           o_data_out,
    output logic [NUM_MODULES-1:0]      o_cs_vec,
    output logic                        o_fetch_cmd,
    output logic                        o_load_cmd,
    input  logic [NUM_MODULES*8-1:0]    i_data_in
);

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_sck_level;
    logic w_cs_b;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;
    logic w_mosi_rise;
    logic w_mosi_fall;
    logic w_unused_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .i_sys_clk (i_sys_clk),
        .i_rst     (i_rst),
        .i_async   (i_spi_sck),
        .o_level   (w_sck_level),
        .o_rise_c  (w_sck_rise),
        .o_fall_c  (w_sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_sys_clk (i_sys_clk),
        .i_rst     (i_rst),
        .i_async   (i_spi_cs_b),
        .o_level   (w_cs_b),
        .o_rise_c  (w_cs_rise),
        .o_fall_c  (w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_sys_clk (i_sys_clk),
        .i_rst     (i_rst),
        .i_async   (i_spi_mosi),
        .o_level   (w_mosi),
        .o_rise_c  (w_mosi_rise),
        .o_fall_c  (w_mosi_fall)
    );

    assign w_unused_edges = w_sck_level ^ w_cs_rise ^ w_cs_fall ^ w_mosi_rise ^ w_mosi_fall;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [BYTE_W-2:0]      r_shift;
    logic [BYTE_W-2:0]      r_tx;
    logic [MOD_W-1:0]       r_mod;
    logic                   r_is_write;
    logic                   r_spi_miso;
    logic [IOC_W-1:0]       r_ioc;
    logic [BYTE_W-1:0]      r_data_out;
    logic [NUM_MODULES-1:0] r_cs_vec;
    logic                   r_fetch_cmd;
    logic                   r_load_cmd;

    logic [BYTE_W-1:0]      w_shift_next;
    logic [BYTE_W-1:0]      w_sel_byte;

    assign w_shift_next = {r_shift, w_mosi};
    assign w_sel_byte   = i_data_in[{r_mod, 3'b000} +: BYTE_W];

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_mod       <= '0;
            r_is_write  <= 1'b0;
            r_spi_miso  <= 1'b0;
            r_ioc       <= '0;
            r_data_out  <= '0;
            r_cs_vec    <= '0;
            r_fetch_cmd <= 1'b0;
            r_load_cmd  <= 1'b0;
        end else begin
            r_fetch_cmd <= 1'b0;
            r_load_cmd  <= 1'b0;
            // CS_b high ends the transaction from any active state, including a normal DONE exit.
            if (r_state != ST_IDLE && w_cs_b) begin
                r_state    <= ST_IDLE;
                r_cs_vec   <= '0;
                r_spi_miso <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_cs_b) begin
                            r_state   <= ST_CMD;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sck_rise) begin
                            r_shift   <= w_shift_next[BYTE_W-2:0];
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            if (r_bit_cnt == CMD_BITS - CNT_W'(1)) begin
                                r_ioc      <= w_shift_next[CMD_IOC_MSB:0];
                                r_mod      <= w_shift_next[CMD_MOD_MSB:CMD_MOD_LSB];
                                r_cs_vec   <= NUM_MODULES'(1'b1) << w_shift_next[CMD_MOD_MSB:CMD_MOD_LSB];
                                r_is_write <= w_shift_next[CMD_RW_BIT];
                                if (w_shift_next[CMD_RW_BIT]) begin
                                    r_state <= ST_DATA;
                                end else begin
                                    r_state     <= ST_FETCH;
                                    r_fetch_cmd <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_FETCH: begin
                        r_state <= ST_WAIT_RD;
                    end
                    ST_WAIT_RD: begin
                        r_tx       <= w_sel_byte[BYTE_W-2:0];
                        r_spi_miso <= w_sel_byte[BYTE_W-1];
                        r_state    <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (r_is_write) begin
                            if (w_sck_rise) begin
                                r_shift   <= w_shift_next[BYTE_W-2:0];
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                                if (r_bit_cnt == TOTAL_BITS - CNT_W'(1)) begin
                                    r_data_out <= w_shift_next;
                                    r_load_cmd <= 1'b1;
                                    r_state    <= ST_LOAD;
                                end
                            end
                        end else begin
                            // The fall between rise 8 and rise 9 must not shift: MSB is already on the line.
                            if (w_sck_fall && r_bit_cnt != CMD_BITS) begin
                                r_spi_miso <= r_tx[BYTE_W-2];
                                r_tx       <= {r_tx[BYTE_W-3:0], 1'b0};
                            end
                            if (w_sck_rise) begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                                if (r_bit_cnt == TOTAL_BITS - CNT_W'(1)) begin
                                    r_spi_miso <= 1'b0;
                                    r_state    <= ST_DONE;
                                end
                            end
                        end
                    end
                    ST_LOAD: begin
                        r_state <= ST_DONE;
                    end
                    ST_DONE: begin
                        r_state <= ST_DONE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_spi_miso  = r_spi_miso;
    assign o_ioc       = r_ioc;
    assign o_data_out  = r_data_out;
    assign o_cs_vec    = r_cs_vec;
    assign o_fetch_cmd = r_fetch_cmd;
    assign o_load_cmd  = r_load_cmd;

endmodule

// File: tb/tb_ioc_spi_initiator.sv
// Directed and randomised SPI transactions against ioc_spi_initiator at f_sck = f_sys/8.
module tb_ioc_spi_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        mosi;
    logic        cs_b;
    logic        miso;
    logic [4:0]  ioc;
    logic [7:0]  data_out;
    logic [3:0]  cs_vec;
    logic        fetch_cmd;
    logic        load_cmd;
    logic [31:0] data_in;

    int n_vec = 0;
    int n_err = 0;

    int         n_load  = 0;
    int         n_fetch = 0;
    int         n_both  = 0;
    logic [4:0] ld_ioc;
    logic [7:0] ld_data;
    logic [3:0] ld_cs;
    logic [4:0] fe_ioc;
    logic [3:0] fe_cs;

    ioc_spi_initiator #(.NUM_MODULES(4), .SYNC_STAGES(2)) dut (
        .i_sys_clk   (clk),
        .i_rst       (rst),
        .i_spi_sck   (sck),
        .i_spi_mosi  (mosi),
        .i_spi_cs_b  (cs_b),
        .o_spi_miso  (miso),
        .o_ioc       (ioc),
        .o_data_out  (data_out),
        .o_cs_vec    (cs_vec),
        .o_fetch_cmd (fetch_cmd),
        .o_load_cmd  (load_cmd),
        .i_data_in   (data_in)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts cycles each strobe is high and snapshots the bus while it is.
    always @(posedge clk) begin
        if (load_cmd) begin
            n_load  <= n_load + 1;
            ld_ioc  <= ioc;
            ld_data <= data_out;
            ld_cs   <= cs_vec;
        end
        if (fetch_cmd) begin
            n_fetch <= n_fetch + 1;
            fe_ioc  <= ioc;
            fe_cs   <= cs_vec;
        end
        if (load_cmd && fetch_cmd) n_both <= n_both + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode 0, MSB first: bits are taken from bits[31] downward; MISO sampled at each rise.
    task automatic spi_xfer(input logic [31:0] bits, input int n, output logic [31:0] rx);
        rx   = '0;
        cs_b = 1'b0;
        wait_clks(3);
        for (int i = 0; i < n; i++) begin
            mosi = bits[31-i];
            wait_clks(4);
            sck = 1'b1;
            rx  = {rx[30:0], miso};
            wait_clks(4);
            sck = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic spi_end();
        wait_clks(4);
        cs_b = 1'b1;
        wait_clks(6);
    endtask

    initial begin
        logic [31:0] rx;
        int          l0;
        int          f0;
        logic [7:0]  cmd;
        logic [7:0]  dat;
        logic [7:0]  exp_b;
        int          m;

        rst     = 1'b1;
        sck     = 1'b0;
        mosi    = 1'b0;
        cs_b    = 1'b1;
        data_in = 32'h96A5C35A;
        wait_clks(3);
        check("reset_outputs", {26'(0), miso, ioc, data_out, cs_vec, fetch_cmd, load_cmd}, 32'h0);
        rst = 1'b0;
        wait_clks(4);

        // Write 0x86 / 0x05
        l0 = n_load; f0 = n_fetch;
        spi_xfer({8'h86, 8'h05, 16'h0}, 16, rx);
        wait_clks(2);
        check("wr_ioc",    32'(ioc), 32'h06);
        check("wr_cs_vec", 32'(cs_vec), 32'h1);
        check("wr_data",   32'(data_out), 32'h05);
        check("wr_load_n", 32'(n_load - l0), 32'd1);
        check("wr_fetch_n", 32'(n_fetch - f0), 32'd0);
        check("wr_load_bus", {13'h0, ld_ioc, ld_data, 2'b0, ld_cs}, {13'h0, 5'h06, 8'h05, 2'b0, 4'h1});
        check("wr_miso_quiet", rx, 32'h0);
        spi_end();
        check("wr_cs_clear", 32'(cs_vec), 32'h0);

        // Read module 2 (0xA5) with command 0x42
        l0 = n_load; f0 = n_fetch;
        spi_xfer({8'h42, 8'h00, 16'h0}, 16, rx);
        wait_clks(2);
        check("rd_cs_vec",  32'(cs_vec), 32'h4);
        check("rd_ioc",     32'(ioc), 32'h02);
        check("rd_fetch_n", 32'(n_fetch - f0), 32'd1);
        check("rd_load_n",  32'(n_load - l0), 32'd0);
        check("rd_fetch_bus", {23'h0, fe_ioc, fe_cs}, {23'h0, 5'h02, 4'h4});
        check("rd_miso", rx, 32'h000000A5);
        check("rd_miso_done", 32'(miso), 32'h0);
        spi_end();
        check("rd_cs_clear", 32'(cs_vec), 32'h0);

        // Abort a write after 4 data bits
        l0 = n_load;
        spi_xfer({8'h86, 4'hA, 20'h0}, 12, rx);
        spi_end();
        check("ab_load_n",  32'(n_load - l0), 32'd0);
        check("ab_cs_vec",  32'(cs_vec), 32'h0);
        check("ab_data_kept", 32'(data_out), 32'h05);
        l0 = n_load;
        spi_xfer({8'hE1, 8'h3C, 16'h0}, 16, rx);
        wait_clks(2);
        check("ab_next_cs",   32'(cs_vec), 32'h8);
        check("ab_next_ioc",  32'(ioc), 32'h01);
        check("ab_next_data", 32'(data_out), 32'h3C);
        check("ab_next_load", 32'(n_load - l0), 32'd1);
        spi_end();

        // 24 SCK cycles: trailing byte must be ignored
        l0 = n_load; f0 = n_fetch;
        spi_xfer({8'h86, 8'h05, 8'hFF, 8'h00}, 24, rx);
        wait_clks(2);
        check("oc_load_n",  32'(n_load - l0), 32'd1);
        check("oc_fetch_n", 32'(n_fetch - f0), 32'd0);
        check("oc_data",    32'(data_out), 32'h05);
        check("oc_cs_vec",  32'(cs_vec), 32'h1);
        spi_end();

        // Asynchronous reset in the middle of write DATA
        spi_xfer({8'hA3, 4'hF, 20'h0}, 12, rx);
        check("rs_pre_cs", 32'(cs_vec), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check("rs_async_outputs", {26'(0), miso, ioc, data_out, cs_vec, fetch_cmd, load_cmd}, 32'h0);
        cs_b = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(6);
        f0 = n_fetch;
        spi_xfer({8'h00, 8'h00, 16'h0}, 16, rx);
        wait_clks(2);
        check("rs_read_miso",  rx, 32'h0000005A);
        check("rs_read_fetch", 32'(n_fetch - f0), 32'd1);
        check("rs_read_cs",    32'(cs_vec), 32'h1);
        spi_end();

        // Random reads and writes across all modules and IOCs
        for (int k = 0; k < 20; k++) begin
            cmd     = 8'($urandom);
            dat     = 8'($urandom);
            data_in = $urandom;
            m       = int'(cmd[6:5]);
            exp_b   = 8'(data_in >> (8 * m));
            l0 = n_load; f0 = n_fetch;
            spi_xfer({cmd, dat, 16'h0}, 16, rx);
            wait_clks(2);
            if (cmd[7]) begin
                check("rnd_wr_strobes", {16'(n_load - l0), 16'(n_fetch - f0)}, {16'd1, 16'd0});
                check("rnd_wr_bus", {13'h0, ld_ioc, ld_data, 2'b0, ld_cs},
                      {13'h0, cmd[4:0], dat, 2'b0, 4'(4'b0001 << m)});
                check("rnd_wr_miso", rx, 32'h0);
            end else begin
                check("rnd_rd_strobes", {16'(n_load - l0), 16'(n_fetch - f0)}, {16'd0, 16'd1});
                check("rnd_rd_bus", {23'h0, fe_ioc, fe_cs}, {23'h0, cmd[4:0], 4'(4'b0001 << m)});
                check("rnd_rd_miso", rx, {24'h0, exp_b});
            end
            spi_end();
            check("rnd_cs_clear", 32'(cs_vec), 32'h0);
        end

        check("never_both_strobes", 32'(n_both), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
